data_mem_ctrl: RTL and testbench

//  Sequences MEM-stage loads/stores (driven by decoder mem_en / 4-bit mem write enable) onto a

---
 rtl/data_mem_ctrl.sv | 133 +++++++++++++
 tb/tb_data_mem_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: MEM-stage load/store sequencer for a split-handshake data bus
// (req/addr_ok, then data_ok). Keeps one access outstanding at a time and stalls
// IF..MEM until it completes. Captured load data is held in DONE until the MEM
// stage advances.
// Optional feature: define ALIGN_CHECK_EN to reject misaligned half/word accesses
// without going to the bus. addr_err then reports the rejection while in DONE.
module data_mem_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mem_en,
  input  logic [DATA_W/8-1:0] mem_wen,
  input  logic [1:0]          mem_size,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_advance,
  output logic [DATA_W-1:0]   mem_rdata,
  output logic                stall,
  output logic                addr_err,
  output logic                data_req,
  output logic                data_wr,
  output logic [1:0]          data_size,
  output logic [DATA_W/8-1:0] data_wstrb,
  output logic [ADDR_W-1:0]   data_addr,
  output logic [DATA_W-1:0]   data_wdata,
  input  logic                data_addr_ok,
  input  logic                data_data_ok,
  input  logic [DATA_W-1:0]   data_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state;
  logic   is_load;

  // The MEM stage holds its inputs while stalled, so the bus fields are plain
  // pass-throughs; only the request strobe is sequenced.
  assign data_wr    = |mem_wen;
  assign data_size  = mem_size;
  assign data_wstrb = mem_wen;
  assign data_addr  = mem_addr;
  assign data_wdata = mem_wdata;
  assign is_load    = (mem_wen == '0);

  // DONE releases the pipeline; every other state holds it while an access is pending.
  assign stall = mem_en & (state != DONE);

`ifdef ALIGN_CHECK_EN
  logic misaligned;

  // Half-words need an even address, words a 4-byte aligned one; bytes always pass.
  always_comb begin
    // NOTE: give every always_comb output a default first so no path can infer a latch.
    misaligned = 1'b0;
    if (mem_size == 2'b01) misaligned = mem_addr[0];
    else if (mem_size == 2'b10) misaligned = (mem_addr[1:0] != 2'b00);
  end
`else
  assign addr_err = 1'b0;
`endif

  // Access sequencer: IDLE -> REQ -> WAIT -> DONE -> IDLE with registered request and load data.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous here; the rst branch only takes effect on a clock edge.
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
      state     <= IDLE;
      data_req  <= 1'b0;
      mem_rdata <= '0;
`ifdef ALIGN_CHECK_EN
      addr_err  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          // data_ok seen here belongs to no access of ours and is ignored.
          if (mem_en) begin
`ifdef ALIGN_CHECK_EN
            if (misaligned) begin
              state    <= DONE;
              addr_err <= 1'b1;
            end else
`endif
            begin
              state    <= REQ;
              data_req <= 1'b1;
            end
          end
        end
        REQ: begin
          // A data_ok without addr_ok cannot belong to this request yet.
          if (data_addr_ok) begin
            data_req <= 1'b0;
            if (data_data_ok) begin
              state <= DONE;
              if (is_load) mem_rdata <= data_rdata;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (data_data_ok) begin
            state <= DONE;
            if (is_load) mem_rdata <= data_rdata;
          end
        end
        DONE: begin
          // Stay here until MEM really moves on, so an external stall cannot
          // cause the same access to be issued twice.
          if (mem_advance) begin
            state <= IDLE;
`ifdef ALIGN_CHECK_EN
            addr_err <= 1'b0;
`endif
          end
        end
        default: begin
          state    <= IDLE;
          data_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl. A reactive bus slave answers requests
// after chosen delays. The expected stall length, request length and held load
// data come from a transaction-level model of the handshake. Directed cases come
// first, then randomized accesses. When ALIGN_CHECK_EN is defined, the misaligned
// case expects a rejection instead of a bus access.
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_en;
  logic [3:0]  mem_wen;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_advance;
  logic [31:0] mem_rdata;
  logic        stall;
  logic        addr_err;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_rdata;

  data_mem_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .mem_en(mem_en), .mem_wen(mem_wen), .mem_size(mem_size),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_advance(mem_advance),
    .mem_rdata(mem_rdata), .stall(stall), .addr_err(addr_err), .data_req(data_req),
    .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One complete access: issue, answer from the slave after a_dly request cycles,
  // then d_dly wait cycles (0 means data_ok together with addr_ok), hold DONE for
  // adv_dly cycles, then advance.
  task automatic run_txn(input string tag, input bit load, input logic [31:0] addr,
                         input logic [1:0] size, input logic [31:0] wdata,
                         input logic [3:0] wen, input int a_dly, input int d_dly,
                         input int adv_dly, input logic [31:0] rd);
    int stall_cnt = 0;
    int req_cnt   = 0;
    int wait_cnt  = 0;
    int bad_bus   = 0;
    int bad_hold  = 0;
    bit accepted  = 0;
    bit responded = 0;
    bit done      = 0;
    int cyc       = 0;
    @(negedge clk);
    mem_en      = 1'b1;
    mem_wen     = load ? 4'b0000 : wen;
    mem_size    = size;
    mem_addr    = addr;
    mem_wdata   = wdata;
    mem_advance = 1'b0;
    while (!done && cyc < 64) begin
      data_addr_ok = 1'b0;
      data_data_ok = 1'b0;
      data_rdata   = $urandom;
      if (data_req && !accepted) begin
        if (data_wr !== !load || data_addr !== addr || data_size !== size ||
            data_wstrb !== mem_wen || data_wdata !== wdata) bad_bus++;
        if (req_cnt == a_dly) begin
          data_addr_ok = 1'b1;
          accepted     = 1'b1;
          if (d_dly == 0) begin
            data_data_ok = 1'b1;
            data_rdata   = rd;
            responded    = 1'b1;
          end
        end else begin
          // A data_ok without addr_ok carries junk and must be ignored.
          data_data_ok = 1'($urandom_range(0, 1));
        end
        req_cnt++;
      end else if (accepted && !responded) begin
        wait_cnt++;
        if (wait_cnt == d_dly) begin
          data_data_ok = 1'b1;
          data_rdata   = rd;
          responded    = 1'b1;
        end
      end
      #1;
      if (stall) stall_cnt++;
      else done = 1'b1;
      cyc++;
      if (!done) @(negedge clk);
    end
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    if (!done) begin
      check({tag, "_timeout"}, 32'd0, 32'd1);
      rst = 1'b1;
      mem_en = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      exp_rdata = '0;
      return;
    end
    if (load) exp_rdata = rd;
    check({tag, "_stall_cycles"}, stall_cnt, 2 + a_dly + d_dly);
    check({tag, "_req_cycles"}, req_cnt, a_dly + 1);
    check({tag, "_bus_fields"}, bad_bus, 0);
    check({tag, "_rdata"}, mem_rdata, exp_rdata);
    check({tag, "_addr_err"}, {31'd0, addr_err}, 32'd0);
    for (int i = 0; i < adv_dly; i++) begin
      @(negedge clk);
      #1;
      if (stall || data_req || mem_rdata !== exp_rdata) bad_hold++;
    end
    if (adv_dly > 0) check({tag, "_done_hold"}, bad_hold, 0);
    @(negedge clk);
    mem_advance = 1'b1;
    @(negedge clk);
    mem_advance = 1'b0;
    mem_en      = 1'b0;
    mem_wen     = 4'b0000;
  endtask

  initial begin
    logic        ld;
    logic [1:0]  sz;
    logic [31:0] ad;
    logic [3:0]  we;
    rst          = 1'b1;
    mem_en       = 1'b0;
    mem_wen      = 4'b0000;
    mem_size     = 2'b10;
    mem_addr     = '0;
    mem_wdata    = '0;
    mem_advance  = 1'b0;
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    data_rdata   = '0;
    exp_rdata    = '0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_stall", {31'd0, stall}, 32'd0);
    check("reset_req", {31'd0, data_req}, 32'd0);
    check("reset_addr_err", {31'd0, addr_err}, 32'd0);
    check("reset_rdata", mem_rdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Zero-wait load, delayed store, and a load held in DONE by another stall.
    run_txn("lw_0wait", 1, 32'h100, 2'b10, 32'h0, 4'b0000, 0, 0, 0, 32'hDEADBEEF);
    run_txn("sw_delay", 0, 32'h200, 2'b10, 32'h12345678, 4'b1111, 2, 3, 0, 32'hCAFEF00D);
    run_txn("lw_hold", 1, 32'h104, 2'b10, 32'h0, 4'b0000, 1, 1, 3, 32'hA5A55A5A);

    // Stray data_ok while idle must not disturb anything.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      data_data_ok = 1'b1;
      data_rdata   = $urandom;
    end
    @(negedge clk);
    data_data_ok = 1'b0;
    #1;
    check("stray_rdata", mem_rdata, exp_rdata);
    check("stray_req", {31'd0, data_req}, 32'd0);

    // Misaligned word load.
`ifdef ALIGN_CHECK_EN
    @(negedge clk);
    mem_en = 1'b1; mem_wen = 4'b0000; mem_size = 2'b10; mem_addr = 32'h102;
    #1;
    check("mis_idle_stall", {31'd0, stall}, 32'd1);
    @(negedge clk);
    #1;
    check("mis_no_req", {31'd0, data_req}, 32'd0);
    check("mis_addr_err", {31'd0, addr_err}, 32'd1);
    check("mis_stall", {31'd0, stall}, 32'd0);
    check("mis_rdata", mem_rdata, exp_rdata);
    mem_advance = 1'b1;
    @(negedge clk);
    mem_advance = 1'b0;
    mem_en      = 1'b0;
    #1;
    check("mis_err_clear", {31'd0, addr_err}, 32'd0);
`else
    run_txn("mis_issued", 1, 32'h102, 2'b10, 32'h0, 4'b0000, 0, 1, 0, 32'h0BADF00D);
`endif

    // Reset during WAIT; the late data_ok for the aborted load must be dropped.
    @(negedge clk);
    mem_en = 1'b1; mem_wen = 4'b0000; mem_size = 2'b10; mem_addr = 32'h300;
    @(negedge clk);
    check("rst_req_issued", {31'd0, data_req}, 32'd1);
    data_addr_ok = 1'b1;
    @(negedge clk);
    data_addr_ok = 1'b0;
    rst    = 1'b1;
    mem_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_rdata = '0;
    #1;
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_req", {31'd0, data_req}, 32'd0);
    check("rst_rdata", mem_rdata, 32'd0);
    @(negedge clk);
    data_data_ok = 1'b1;
    data_rdata   = 32'hBAD0BAD0;
    @(negedge clk);
    data_data_ok = 1'b0;
    @(negedge clk);
    #1;
    check("rst_late_data_ok", mem_rdata, 32'd0);

    // Randomized loads and stores with naturally aligned addresses.
    for (int t = 0; t < 40; t++) begin
      ld = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 2));
      ad = $urandom;
      case (sz)
        2'b00:   begin we = 4'b0001 << ad[1:0]; end
        2'b01:   begin ad[0] = 1'b0; we = 4'b0011 << {ad[1], 1'b0}; end
        default: begin ad[1:0] = 2'b00; we = 4'b1111; end
      endcase
      run_txn($sformatf("rnd%0d", t), ld, ad, sz, $urandom, we,
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), $urandom);
    end

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
